if_id_stage: RTL and testbench

- Pipeline register between instruction fetch and decode in the 5-stage MIPS core.
- Captures the PC and instruction produced by the fetch stage each cycle.
- Detects load-use hazards against the EX stage and stalls fetch and decode.
- Squashes the fetched instruction on a taken branch (PCSrc), decodes the instruction fields, and keeps saturating stall/flush event counters for debug.

---
 rtl/if_id_stage.sv | 96 +++++++++
 tb/tb_if_id_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 5-stage MIPS core: load-use stall detection,
// branch squash, instruction field decode and saturating stall/flush counters.
module if_id_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PCSrc,
  input  logic [DATA_W-1:0] if_pc_in,
  input  logic [DATA_W-1:0] if_instruction_in,
  input  logic              ex_MemRead,
  input  logic [4:0]        ex_rt,
  output logic              PCWrite,
  output logic              id_bubble,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instruction,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [5:0]        id_funct,
  output logic [DATA_W-1:0] id_imm_sext,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;
  logic              hazard;

  // A squashed slot has valid_q = 0, so it can never trigger a stall.
  assign hazard = valid_q & ex_MemRead & (ex_rt != 5'd0) &
                  ((ex_rt == instr_q[25:21]) | (ex_rt == instr_q[20:16]));

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (PCSrc) begin
      pc_d    = if_pc_in;
      instr_d = '0;
      valid_d = 1'b0;
      if (flushCnt_q != {CNT_W{1'b1}})
        flushCnt_d = flushCnt_q + CNT_W'(1);
    end else if (hazard) begin
      if (stallCnt_q != {CNT_W{1'b1}})
        stallCnt_d = stallCnt_q + CNT_W'(1);
    end else begin
      pc_d    = if_pc_in;
      instr_d = if_instruction_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  // A taken branch still lets the target load; the held ID instruction is bubbled regardless.
  assign PCWrite   = Reset | PCSrc | ~hazard;
  assign id_bubble = ~Reset & hazard;

  assign id_valid       = valid_q;
  assign id_pc          = pc_q;
  assign id_instruction = instr_q;
  assign id_opcode      = instr_q[31:26];
  assign id_rs          = instr_q[25:21];
  assign id_rt          = instr_q[20:16];
  assign id_rd          = instr_q[15:11];
  assign id_shamt       = instr_q[10:6];
  assign id_funct       = instr_q[5:0];
  assign id_imm_sext    = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};
  assign stall_count    = stallCnt_q;
  assign flush_count    = flushCnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized self-checking bench for if_id_stage: a behavioural pipeline model
// checked every cycle against a default instance and a 4-bit-counter instance.
module tb_if_id_stage;

  logic        Clk;
  logic        Reset;
  logic        PCSrc;
  logic [31:0] if_pc_in;
  logic [31:0] if_instruction_in;
  logic        ex_MemRead;
  logic [4:0]  ex_rt;

  logic        PCWrite, id_bubble, id_valid;
  logic [31:0] id_pc, id_instruction, id_imm_sext;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] stall_count, flush_count;

  logic        PCWrite4, id_bubble4, id_valid4;
  logic [31:0] id_pc4, id_instruction4, id_imm_sext4;
  logic [5:0]  id_opcode4, id_funct4;
  logic [4:0]  id_rs4, id_rt4, id_rd4, id_shamt4;
  logic [3:0]  stall_count4, flush_count4;

  int errors = 0;
  int checks = 0;

  logic [31:0] mPc;
  logic [31:0] mInstr;
  bit          mValid;
  int          mStall;
  int          mFlush;

  if_id_stage u_dut (
    .Clk(Clk), .Reset(Reset), .PCSrc(PCSrc), .if_pc_in(if_pc_in),
    .if_instruction_in(if_instruction_in), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .PCWrite(PCWrite), .id_bubble(id_bubble), .id_valid(id_valid), .id_pc(id_pc),
    .id_instruction(id_instruction), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct), .id_imm_sext(id_imm_sext),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  if_id_stage #(.DATA_W(32), .CNT_W(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .PCSrc(PCSrc), .if_pc_in(if_pc_in),
    .if_instruction_in(if_instruction_in), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .PCWrite(PCWrite4), .id_bubble(id_bubble4), .id_valid(id_valid4), .id_pc(id_pc4),
    .id_instruction(id_instruction4), .id_opcode(id_opcode4), .id_rs(id_rs4), .id_rt(id_rt4),
    .id_rd(id_rd4), .id_shamt(id_shamt4), .id_funct(id_funct4), .id_imm_sext(id_imm_sext4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelHazard();
    return mValid && ex_MemRead && (ex_rt != 5'd0) &&
           (ex_rt == mInstr[25:21] || ex_rt == mInstr[20:16]);
  endfunction

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Inputs change one time unit after the rising edge and settle before the check.
  task automatic applyStimulus(input bit rst, input bit br, input logic [31:0] pc,
                               input logic [31:0] ins, input bit mr, input logic [4:0] rt);
    Reset             = rst;
    PCSrc             = br;
    if_pc_in          = pc;
    if_instruction_in = ins;
    ex_MemRead        = mr;
    ex_rt             = rt;
    #1;
  endtask

  task automatic checkOutput();
    logic signed [15:0] imm16;
    int                 immExt;
    bit                 hz;
    imm16  = mInstr[15:0];
    immExt = imm16;
    hz     = modelHazard();
    chk("PCWrite",     {31'd0, PCWrite},   {31'd0, Reset || PCSrc || !hz});
    chk("id_bubble",   {31'd0, id_bubble}, {31'd0, !Reset && hz});
    chk("id_valid",    {31'd0, id_valid},  {31'd0, mValid});
    chk("id_pc",       id_pc,              mPc);
    chk("id_instr",    id_instruction,     mInstr);
    chk("id_opcode",   {26'd0, id_opcode}, mInstr >> 26);
    chk("id_rs",       {27'd0, id_rs},     (mInstr >> 21) & 32'h1F);
    chk("id_rt",       {27'd0, id_rt},     (mInstr >> 16) & 32'h1F);
    chk("id_rd",       {27'd0, id_rd},     (mInstr >> 11) & 32'h1F);
    chk("id_shamt",    {27'd0, id_shamt},  (mInstr >> 6) & 32'h1F);
    chk("id_funct",    {26'd0, id_funct},  mInstr & 32'h3F);
    chk("id_imm_sext", id_imm_sext,        immExt);
    chk("stall_count", {16'd0, stall_count}, sat(mStall, 65535));
    chk("flush_count", {16'd0, flush_count}, sat(mFlush, 65535));
    chk("PCWrite4",    {31'd0, PCWrite4},  {31'd0, PCWrite});
    chk("id_instr4",   id_instruction4,    mInstr);
    chk("id_valid4",   {31'd0, id_valid4}, {31'd0, mValid});
    chk("stall_count4", {28'd0, stall_count4}, sat(mStall, 15));
    chk("flush_count4", {28'd0, flush_count4}, sat(mFlush, 15));
  endtask

  // Advance the model by one clock using the rules: reset > flush > stall > load.
  task automatic clockEdge();
    bit hz;
    hz = modelHazard();
    @(posedge Clk);
    if (Reset) begin
      mPc = 0; mInstr = 0; mValid = 0; mStall = 0; mFlush = 0;
    end else if (PCSrc) begin
      mPc = if_pc_in; mInstr = 0; mValid = 0; mFlush++;
    end else if (hz) begin
      mStall++;
    end else begin
      mPc = if_pc_in; mInstr = if_instruction_in; mValid = 1;
    end
    #1;
  endtask

  task automatic step(input bit rst, input bit br, input logic [31:0] pc,
                      input logic [31:0] ins, input bit mr, input logic [4:0] rt);
    applyStimulus(rst, br, pc, ins, mr, rt);
    checkOutput();
    clockEdge();
  endtask

  initial begin
    logic [31:0] rpc, rins;
    logic [4:0]  rrt;
    mPc = 0; mInstr = 0; mValid = 0; mStall = 0; mFlush = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    @(posedge Clk); #1;
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    chk("lit_reset_valid", {31'd0, id_valid}, 32'd0);

    step(1'b0, 1'b0, 32'h4, 32'h8C220000, 1'b0, 5'd0);
    chk("lit_pc",    id_pc, 32'h4);
    chk("lit_valid", {31'd0, id_valid}, 32'd1);
    chk("lit_rs",    {27'd0, id_rs}, 32'd1);
    chk("lit_rt",    {27'd0, id_rt}, 32'd2);
    chk("lit_imm0",  id_imm_sext, 32'h0);
    chk("lit_cnt0",  {stall_count, flush_count}, 32'h0);

    step(1'b0, 1'b0, 32'h8, 32'h00441820, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 32'hC, 32'h20010001, 1'b1, 5'd2);
    chk("lit_stall_pcwrite", {31'd0, PCWrite}, 32'd0);
    chk("lit_stall_bubble",  {31'd0, id_bubble}, 32'd1);
    checkOutput();
    clockEdge();
    chk("lit_stall_hold", id_instruction, 32'h00441820);
    chk("lit_stall_cnt",  {16'd0, stall_count}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'hC, 32'h20010001, 1'b0, 5'd0);
    chk("lit_unstall_pcwrite", {31'd0, PCWrite}, 32'd1);
    checkOutput();
    clockEdge();
    chk("lit_unstall_load", id_instruction, 32'h20010001);

    step(1'b0, 1'b0, 32'h10, 32'h00001820, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 32'h14, 32'h00441820, 1'b1, 5'd0);
    chk("lit_zero_rt_pcwrite", {31'd0, PCWrite}, 32'd1);
    checkOutput();
    clockEdge();

    applyStimulus(1'b0, 1'b1, 32'h100, 32'h12345678, 1'b1, 5'd2);
    chk("lit_flush_pcwrite", {31'd0, PCWrite}, 32'd1);
    chk("lit_flush_bubble",  {31'd0, id_bubble}, 32'd1);
    checkOutput();
    clockEdge();
    chk("lit_flush_instr", id_instruction, 32'h0);
    chk("lit_flush_valid", {31'd0, id_valid}, 32'd0);
    chk("lit_flush_cnt",   {16'd0, flush_count}, 32'd1);
    chk("lit_flush_stall", {16'd0, stall_count}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h104, 32'h2002FFF0, 1'b1, 5'd2);
    chk("lit_after_flush_bubble", {31'd0, id_bubble}, 32'd0);
    checkOutput();
    clockEdge();
    chk("lit_imm_neg", id_imm_sext, 32'hFFFFFFF0);
    chk("lit_opcode",  {26'd0, id_opcode}, 32'h08);

    step(1'b0, 1'b0, 32'h108, 32'h00441820, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b0, 32'h10C, 32'h0, 1'b1, 5'd2);
    chk("lit_sat4",    {28'd0, stall_count4}, 32'd15);
    chk("lit_stall21", {16'd0, stall_count}, 32'd21);
    applyStimulus(1'b1, 1'b0, 32'h10C, 32'h0, 1'b1, 5'd2);
    chk("lit_rst_pcwrite", {31'd0, PCWrite}, 32'd1);
    chk("lit_rst_bubble",  {31'd0, id_bubble}, 32'd0);
    checkOutput();
    clockEdge();
    chk("lit_rst_stall", {28'd0, stall_count4}, 32'd0);
    chk("lit_rst_valid", {31'd0, id_valid}, 32'd0);

    // Random phase: bias ex_rt toward the registers the ID instruction reads.
    for (int i = 0; i < 600; i++) begin
      rpc  = {$urandom_range(0, 32'h3FFF), 2'b00};
      rins = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      case ($urandom_range(0, 3))
        0: rrt = mInstr[25:21];
        1: rrt = mInstr[20:16];
        default: rrt = 5'($urandom_range(0, 3));
      endcase
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, rpc, rins,
           1'($urandom), rrt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
